fetch_decode_queue: RTL and testbench

//  Parametrised IF->ID boundary: a DEPTH-entry FIFO of fetched instructions. Each entry holds

---
 rtl/fetch_decode_queue.sv | 96 +++++++++
 tb/tb_fetch_decode_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO of {instr, PC, PC+4, prediction}
// with valid/ready on both sides, single-cycle FLUSH and zeroed outputs when empty.
module fetch_decode_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PRED_W = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [DATA_W-1:0]        Instr1_IF,
    input  logic [31:0]              Instr_PC_IF,
    input  logic [31:0]              Instr_PC_Plus4_IF,
    input  logic [PRED_W-1:0]        Branch_pred_IN,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [DATA_W-1:0]        Instr1_OUT,
    output logic [31:0]              Instr_PC_OUT,
    output logic [31:0]              Instr_PC_Plus4,
    output logic [PRED_W-1:0]        Branch_pred_OUT,
    output logic [31:0]              Instr_pc_stall,
    output logic [$clog2(DEPTH):0]   Count_OUT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [31:0]       pc_mem    [DEPTH];
    logic [31:0]       pc4_mem   [DEPTH];
    logic [PRED_W-1:0] pred_mem  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Handshake is decoded from registered count only, so IN_READY never
    // depends on OUT_READY and there is no full-queue pass-through path.
    assign IN_READY  = (count != CW'(DEPTH));
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;
    assign Count_OUT = count;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by count,
    // so stale contents are never observable and the array maps to plain RAM.
    always_ff @(posedge CLK) begin
        if (RESET && !FLUSH && push) begin
            instr_mem[wr_ptr] <= Instr1_IF;
            pc_mem[wr_ptr]    <= Instr_PC_IF;
            pc4_mem[wr_ptr]   <= Instr_PC_Plus4_IF;
            pred_mem[wr_ptr]  <= Branch_pred_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            Instr_pc_stall <= '0;
        end else if (!FLUSH && OUT_VALID && !OUT_READY) begin
            Instr_pc_stall <= Instr_PC_OUT;
        end
    end

    // Empty queue presents all-zero payload so decode sees a NOP bubble.
    assign Instr1_OUT      = OUT_VALID ? instr_mem[rd_ptr] : '0;
    assign Instr_PC_OUT    = OUT_VALID ? pc_mem[rd_ptr]    : '0;
    assign Instr_PC_Plus4  = OUT_VALID ? pc4_mem[rd_ptr]   : '0;
    assign Branch_pred_OUT = OUT_VALID ? pred_mem[rd_ptr]  : '0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=4): reset, single pass, fill,
// concurrent push/pop with wrap, flush and mid-stream reset.
module tb_fetch_decode_queue;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic [0:0]  Branch_pred_IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4;
    logic [0:0]  Branch_pred_OUT;
    logic [31:0] Instr_pc_stall;
    logic [2:0]  Count_OUT;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_decode_queue #(.DATA_W(32), .DEPTH(4), .PRED_W(1)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF),
        .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF), .Branch_pred_IN(Branch_pred_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
        .Instr_PC_Plus4(Instr_PC_Plus4), .Branch_pred_OUT(Branch_pred_OUT),
        .Instr_pc_stall(Instr_pc_stall), .Count_OUT(Count_OUT)
    );

    always #5 CLK = ~CLK;

    // One rising edge, then settle 1 time unit so outputs are sampled away from it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        IN_VALID          = v;
        Instr_PC_IF       = pc;
        Instr_PC_Plus4_IF = pc + 32'd4;
        Instr1_IF         = instr;
        Branch_pred_IN    = pc[2];
    endtask

    task automatic test_reset();
        RESET = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        step();
        RESET = 1'b1;
        tests_run++;
        if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b exp 0", OUT_VALID); end
        tests_run++;
        if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Branch_pred_OUT} !== 97'd0) begin
            tests_failed++; $display("FAIL reset_payload got %h %h %h %h exp all zero", Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Branch_pred_OUT);
        end
        tests_run++;
        if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0b exp 1", IN_READY); end
        tests_run++;
        if (Count_OUT !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", Count_OUT); end
        tests_run++;
        if (Instr_pc_stall !== 32'd0) begin tests_failed++; $display("FAIL reset_pc_stall got %h exp 0", Instr_pc_stall); end
    endtask

    task automatic test_single_pass();
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; Instr1_IF = 32'h0000_0013; Instr_PC_IF = 32'h400;
        Instr_PC_Plus4_IF = 32'h404; Branch_pred_IN = 1'b1;
        #1;
        tests_run++;
        if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL single_no_bypass got %0b exp 0", OUT_VALID); end
        step();
        IN_VALID = 1'b0;
        tests_run++;
        if ({OUT_VALID, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Branch_pred_OUT, Count_OUT} !==
            {1'b1, 32'h13, 32'h400, 32'h404, 1'b1, 3'd1}) begin
            tests_failed++; $display("FAIL single_head got v=%0b i=%h pc=%h pc4=%h p=%0b c=%0d exp 1 13 400 404 1 1",
                OUT_VALID, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Branch_pred_OUT, Count_OUT);
        end
        step();
        tests_run++;
        if (Count_OUT !== 3'd0 || OUT_VALID !== 1'b0 || Instr1_OUT !== 32'd0) begin
            tests_failed++; $display("FAIL single_popped got c=%0d v=%0b i=%h exp 0 0 0", Count_OUT, OUT_VALID, Instr1_OUT);
        end
    endtask

    task automatic test_fill();
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_in(1'b1, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
            step();
        end
        tests_run++;
        if (Count_OUT !== 3'd4 || IN_READY !== 1'b0) begin
            tests_failed++; $display("FAIL fill_full got c=%0d rdy=%0b exp 4 0", Count_OUT, IN_READY);
        end
        tests_run++;
        if (Instr_pc_stall !== 32'h400) begin tests_failed++; $display("FAIL fill_pc_stall got %h exp 400", Instr_pc_stall); end
        drive_in(1'b0, 32'h0, 32'h0);
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (Instr_PC_OUT !== 32'h400 + 32'(4 * i) || Instr1_OUT !== 32'h1000 + 32'(i)) begin
                tests_failed++; $display("FAIL fill_drain_%0d got pc=%h i=%h exp pc=%h i=%h",
                    i, Instr_PC_OUT, Instr1_OUT, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
            end
            step();
        end
        tests_run++;
        if (Count_OUT !== 3'd0) begin tests_failed++; $display("FAIL fill_empty got %0d exp 0", Count_OUT); end
    endtask

    task automatic test_back_to_back();
        OUT_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_in(1'b1, 32'h500 + 32'(4 * i), 32'h2000 + 32'(i));
            step();
        end
        OUT_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_in(1'b1, 32'h508 + 32'(4 * k), 32'h2002 + 32'(k));
            tests_run++;
            if (Instr_PC_OUT !== 32'h500 + 32'(4 * k) || Instr_PC_Plus4 !== 32'h504 + 32'(4 * k)) begin
                tests_failed++; $display("FAIL b2b_head_%0d got pc=%h pc4=%h exp pc=%h", k, Instr_PC_OUT, Instr_PC_Plus4, 32'h500 + 32'(4 * k));
            end
            step();
            tests_run++;
            if (Count_OUT !== 3'd2) begin tests_failed++; $display("FAIL b2b_count_%0d got %0d exp 2", k, Count_OUT); end
        end
        drive_in(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (Instr_PC_OUT !== 32'h520 + 32'(4 * i)) begin
                tests_failed++; $display("FAIL b2b_tail_%0d got %h exp %h", i, Instr_PC_OUT, 32'h520 + 32'(4 * i));
            end
            step();
        end
    endtask

    task automatic test_flush();
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, 32'h600 + 32'(4 * i), 32'h3000 + 32'(i));
            step();
        end
        drive_in(1'b1, 32'h60C, 32'h3003);
        OUT_READY = 1'b1;
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        tests_run++;
        if (Count_OUT !== 3'd0 || OUT_VALID !== 1'b0 || Instr_PC_OUT !== 32'd0) begin
            tests_failed++; $display("FAIL flush_empty got c=%0d v=%0b pc=%h exp 0 0 0", Count_OUT, OUT_VALID, Instr_PC_OUT);
        end
        tests_run++;
        if (Instr_pc_stall !== 32'h600) begin tests_failed++; $display("FAIL flush_pc_stall got %h exp 600", Instr_pc_stall); end
        OUT_READY = 1'b0;
        drive_in(1'b1, 32'h700, 32'h4000);
        step();
        drive_in(1'b0, 32'h0, 32'h0);
        tests_run++;
        if (Count_OUT !== 3'd1 || Instr_PC_OUT !== 32'h700 || Instr1_OUT !== 32'h4000) begin
            tests_failed++; $display("FAIL flush_next_head got c=%0d pc=%h i=%h exp 1 700 4000", Count_OUT, Instr_PC_OUT, Instr1_OUT);
        end
        OUT_READY = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, 32'h800 + 32'(4 * i), 32'h5000 + 32'(i));
            step();
        end
        tests_run++;
        if (Count_OUT !== 3'd4 || Instr_pc_stall !== 32'h800) begin
            tests_failed++; $display("FAIL rmid_full got c=%0d stall=%h exp 4 800", Count_OUT, Instr_pc_stall);
        end
        test_reset();
        drive_in(1'b1, 32'h900, 32'h0ABC);
        step();
        drive_in(1'b0, 32'h0, 32'h0);
        tests_run++;
        if (Count_OUT !== 3'd1 || Instr_PC_OUT !== 32'h900 || Instr1_OUT !== 32'h0ABC) begin
            tests_failed++; $display("FAIL rmid_restart got c=%0d pc=%h i=%h exp 1 900 abc", Count_OUT, Instr_PC_OUT, Instr1_OUT);
        end
    endtask

    initial begin
        RESET = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        #2;
        test_reset();
        test_single_pass();
        test_fill();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
